cselect_split6_6b: RTL

CSELECT_SPLIT6_6B -- requirements
Module: cSelectSplit6_6b

---
 rtl/cselect_split6_6b_if.sv | 31 +++
 rtl/cselect_split6_6b.sv | 102 ++++++++++
 2 files changed

// File: rtl/cselect_split6_6b_if.sv
// Token bus between one upstream source and six downstream destinations.
interface cselect_split6_6b_if;
   logic       i_drive;
   logic [5:0] i_data;
   logic [2:0] i_sel;
   logic       o_free;
   logic       o_drive0, o_drive1, o_drive2, o_drive3, o_drive4, o_drive5;
   logic [5:0] o_data;
   logic [2:0] o_dst;
   logic       i_free0, i_free1, i_free2, i_free3, i_free4, i_free5;
   logic       o_busy;
   logic       o_err;
   logic       o_ovf;
   logic [7:0] o_cnt;

   // Upstream source and destinations (drives the i_* side)
   modport master (
      output i_drive, i_data, i_sel,
      output i_free0, i_free1, i_free2, i_free3, i_free4, i_free5,
      input  o_free, o_data, o_dst, o_busy, o_err, o_ovf, o_cnt,
      input  o_drive0, o_drive1, o_drive2, o_drive3, o_drive4, o_drive5
   );

   // Splitter (drives the o_* side)
   modport slave (
      input  i_drive, i_data, i_sel,
      input  i_free0, i_free1, i_free2, i_free3, i_free4, i_free5,
      output o_free, o_data, o_dst, o_busy, o_err, o_ovf, o_cnt,
      output o_drive0, o_drive1, o_drive2, o_drive3, o_drive4, o_drive5
   );
endinterface

// File: rtl/cselect_split6_6b.sv
// One-token-at-a-time splitter: routes a 6-bit token to one of six
// destinations, waits for that destination's acknowledge, then frees upstream.
module cselect_split6_6b (
   input logic               clk,
   input logic               rst,
   cselect_split6_6b_if.slave bus
);
   localparam int unsigned DW   = 6;
   localparam int unsigned SW   = 3;
   localparam int unsigned NDST = 6;
   localparam int unsigned CW   = 8;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t          state;
   logic [NDST-1:0] drive_q;
   logic [DW-1:0]   data_q;
   logic [SW-1:0]   dst_q;
   logic            free_q;
   logic            busy_q;
   logic            err_q;
   logic            ovf_q;
   logic [CW-1:0]   cnt_q;

   logic [NDST-1:0] free_vec;
   logic [NDST-1:0] dst_hot;
   logic            ack;

   // Only the acknowledge of the current owner of o_data counts
   assign free_vec = {bus.i_free5, bus.i_free4, bus.i_free3,
                      bus.i_free2, bus.i_free1, bus.i_free0};
   assign dst_hot  = NDST'(1) << dst_q;
   assign ack      = |(free_vec & dst_hot);

   // Token FSM with registered strobes, payload capture and delivery counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         drive_q <= '0;
         data_q  <= '0;
         dst_q   <= '0;
         free_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         drive_q <= '0;
         free_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_drive) begin
                  busy_q <= 1'b1;
                  if (bus.i_sel <= SW'(NDST - 1)) begin
                     data_q  <= bus.i_data;
                     dst_q   <= bus.i_sel;
                     drive_q <= NDST'(1) << bus.i_sel;
                     state   <= SEND;
                  end else begin
                     // Illegal destination: flag it and release upstream at once
                     err_q  <= 1'b1;
                     free_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            SEND, WAIT: begin
               ovf_q <= bus.i_drive;
               if (ack) begin
                  free_q <= 1'b1;
                  cnt_q  <= cnt_q + CW'(1);
                  state  <= DONE;
               end else begin
                  state  <= WAIT;
               end
            end
            DONE: begin
               ovf_q  <= bus.i_drive;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_drive0 = drive_q[0];
   assign bus.o_drive1 = drive_q[1];
   assign bus.o_drive2 = drive_q[2];
   assign bus.o_drive3 = drive_q[3];
   assign bus.o_drive4 = drive_q[4];
   assign bus.o_drive5 = drive_q[5];
   assign bus.o_data   = data_q;
   assign bus.o_dst    = dst_q;
   assign bus.o_free   = free_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_err    = err_q;
   assign bus.o_ovf    = ovf_q;
   assign bus.o_cnt    = cnt_q;
endmodule
